// File: rtl/wr_bank_ctrl_if.sv
// wr_bank_ctrl_if: entry handshake, bank free/lock and bank RAM write bus of the reorder FIFO write side
interface wr_bank_ctrl_if #(
  parameter int DEPTH = 8,
  parameter int DW = 32,
  parameter int TW = $clog2(DEPTH)
);
  logic in_valid;
  logic [TW-1:0] in_tag;
  logic [DW-1:0] in_data;
  logic in_ready;
  logic mem0_free;
  logic mem1_free;
  logic mem0_lock;
  logic mem1_lock;
  logic mem_we;
  logic mem_sel;
  logic [TW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic dup_err;
  modport master (
    output in_valid, in_tag, in_data, mem0_free, mem1_free,
    input in_ready, mem0_lock, mem1_lock, mem_we, mem_sel, mem_waddr, mem_wdata, dup_err
  );
  modport slave (
    input in_valid, in_tag, in_data, mem0_free, mem1_free,
    output in_ready, mem0_lock, mem1_lock, mem_we, mem_sel, mem_waddr, mem_wdata, dup_err
  );
endinterface

// File: rtl/wr_bank_ctrl.sv
// wr_bank_ctrl: double-buffered reorder FIFO write side; WR_DUP_CHECK_EN drops duplicate-tag accepts and pulses dup_err
module wr_bank_ctrl #(
  parameter int DEPTH = 8,
  parameter int DW = 32,
  parameter int TW = $clog2(DEPTH)
) (
  input logic clk,
  input logic rst,
  wr_bank_ctrl_if.slave bus
);
  typedef enum logic [2:0] {WR0 = 3'b001, WR1 = 3'b010, WRWAIT = 3'b100} state_t;
  state_t state, state_n;
  logic [1:0][DEPTH-1:0] bm, bm_n;
  logic [1:0] lock, lock_n, free;
  logic [DEPTH-1:0] hot, fill;
  logic act, acc, done, wr;
  logic we_q, sel_q;
  logic [TW-1:0] waddr_q;
  logic [DW-1:0] wdata_q;
`ifdef WR_DUP_CHECK_EN
  logic dup, err_q;
  assign dup = bm[act][bus.in_tag];
  assign wr = acc && !dup;
  assign bus.dup_err = err_q;
`else
  assign wr = acc;
  assign bus.dup_err = 1'b0;
`endif
  assign bus.in_ready = state != WRWAIT;
  assign bus.mem0_lock = lock[0];
  assign bus.mem1_lock = lock[1];
  assign bus.mem_we = we_q;
  assign bus.mem_sel = sel_q;
  assign bus.mem_waddr = waddr_q;
  assign bus.mem_wdata = wdata_q;
  always_comb begin
    free = {bus.mem1_free, bus.mem0_free};
    act = state == WR1;
    acc = bus.in_valid && state != WRWAIT;
    hot = acc ? DEPTH'(1) << bus.in_tag : '0;
    fill = bm[act] | hot;
    done = acc && &fill;
    bm_n = bm;
    for (int i = 0; i < 2; i++) bm_n[i] = (lock[i] && free[i]) ? '0 : bm[i];
    if (acc) bm_n[act] = fill;
    lock_n = lock & ~free;
    if (done) lock_n[act] = 1'b1;
    state_n = state == WRWAIT ? (free[0] ? WR0 : free[1] ? WR1 : WRWAIT)
            : !done ? state
            : (!lock[~act] || free[~act]) ? (act ? WR0 : WR1) : WRWAIT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WR0;
      bm <= '0;
      lock <= '0;
      we_q <= 1'b0;
      sel_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
`ifdef WR_DUP_CHECK_EN
      err_q <= 1'b0;
`endif
    end else begin
      state <= state_n;
      bm <= bm_n;
      lock <= lock_n;
      we_q <= wr;
`ifdef WR_DUP_CHECK_EN
      err_q <= acc && dup;
`endif
      if (acc) begin
        sel_q <= act;
        waddr_q <= bus.in_tag;
        wdata_q <= bus.in_data;
      end
    end
  end
endmodule

// File: tb/tb_wr_bank_ctrl.sv
// tb_wr_bank_ctrl: directed self-checking bench for wr_bank_ctrl
module tb_wr_bank_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [2:0] tags0 [8] = '{3'd7, 3'd3, 3'd0, 3'd5, 3'd1, 3'd6, 3'd2, 3'd4};
  logic [2:0] rest [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
  logic [2:0] dtags [6] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
  wr_bank_ctrl_if #(.DEPTH(8), .DW(32)) bus ();
  wr_bank_ctrl #(.DEPTH(8), .DW(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] tag, input logic [31:0] data);
    bus.in_valid = 1'b1;
    bus.in_tag = tag;
    bus.in_data = data;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_tag = '0; bus.in_data = '0; bus.mem0_free = 1'b0; bus.mem1_free = 1'b0;
    rst = 1'b1;
    tick(); tick();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.mem0_lock !== 1'b0 || bus.mem1_lock !== 1'b0) begin errors++; $display("FAIL reset_locks: got %b%b expected 00", bus.mem1_lock, bus.mem0_lock); end
    checks++; if (bus.mem_we !== 1'b0 || bus.dup_err !== 1'b0) begin errors++; $display("FAIL reset_we_err: got we=%b err=%b expected 0 0", bus.mem_we, bus.dup_err); end
    checks++; if (bus.mem_sel !== 1'b0 || bus.mem_waddr !== 3'd0 || bus.mem_wdata !== 32'd0) begin errors++; $display("FAIL reset_bus: got sel=%b addr=%0d data=%h expected 0 0 0", bus.mem_sel, bus.mem_waddr, bus.mem_wdata); end
    rst = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      drive(tags0[i], 32'hA000_0000 + i);
      checks++; if (bus.mem_we !== 1'b1 || bus.mem_sel !== 1'b0) begin errors++; $display("FAIL fill_we_sel[%0d]: got we=%b sel=%b expected 1 0", i, bus.mem_we, bus.mem_sel); end
      checks++; if (bus.mem_waddr !== tags0[i] || bus.mem_wdata !== 32'hA000_0000 + i) begin errors++; $display("FAIL fill_addr_data[%0d]: got %0d/%h expected %0d/%h", i, bus.mem_waddr, bus.mem_wdata, tags0[i], 32'hA000_0000 + i); end
      checks++; if (bus.mem0_lock !== (i == 7)) begin errors++; $display("FAIL fill_lock0[%0d]: got %b expected %b", i, bus.mem0_lock, i == 7); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d]: got %b expected 1", i, bus.in_ready); end
    end
    tick();
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL fill_idle_we: got %b expected 0", bus.mem_we); end
  endtask

  task automatic test_wait();
    for (int i = 0; i < 8; i++) begin
      drive(3'(i), 32'hB000_0000 + i);
      checks++; if (bus.mem_we !== 1'b1 || bus.mem_sel !== 1'b1 || bus.mem_waddr !== 3'(i)) begin errors++; $display("FAIL wait_fill1[%0d]: got we=%b sel=%b addr=%0d expected 1 1 %0d", i, bus.mem_we, bus.mem_sel, bus.mem_waddr, i); end
    end
    checks++; if (bus.mem1_lock !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL wait_enter: got lock1=%b ready=%b expected 1 0", bus.mem1_lock, bus.in_ready); end
    bus.in_valid = 1'b1; bus.in_tag = 3'd1; bus.in_data = 32'hDEAD_0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus.mem_we !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL wait_hold[%0d]: got we=%b ready=%b expected 0 0", i, bus.mem_we, bus.in_ready); end
    end
    bus.in_valid = 1'b0;
    bus.mem0_free = 1'b1;
    tick();
    bus.mem0_free = 1'b0;
    checks++; if (bus.mem0_lock !== 1'b0 || bus.mem1_lock !== 1'b1 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL wait_free0: got lock0=%b lock1=%b ready=%b expected 0 1 1", bus.mem0_lock, bus.mem1_lock, bus.in_ready); end
    drive(3'd5, 32'hC000_0005);
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_sel !== 1'b0 || bus.mem_wdata !== 32'hC000_0005) begin errors++; $display("FAIL wait_next_write: got we=%b sel=%b data=%h expected 1 0 c0000005", bus.mem_we, bus.mem_sel, bus.mem_wdata); end
  endtask

  task automatic test_overlap();
    for (int i = 0; i < 7; i++) begin
      bus.mem1_free = (i == 6);
      drive(rest[i], 32'hC000_0000 + rest[i]);
      bus.mem1_free = 1'b0;
      checks++; if (bus.in_ready !== 1'b1 || bus.mem_sel !== 1'b0) begin errors++; $display("FAIL ovl_ready_sel[%0d]: got ready=%b sel=%b expected 1 0", i, bus.in_ready, bus.mem_sel); end
    end
    checks++; if (bus.mem0_lock !== 1'b1 || bus.mem1_lock !== 1'b0) begin errors++; $display("FAIL ovl_locks: got lock0=%b lock1=%b expected 1 0", bus.mem0_lock, bus.mem1_lock); end
    drive(3'd0, 32'hD000_0000);
    checks++; if (bus.mem_we !== 1'b1 || bus.mem_sel !== 1'b1) begin errors++; $display("FAIL ovl_switch: got we=%b sel=%b expected 1 1", bus.mem_we, bus.mem_sel); end
  endtask

  task automatic test_dup();
    rst = 1'b1; tick(); rst = 1'b0;
    drive(3'd3, 32'h1111_1111);
    checks++; if (bus.mem_we !== 1'b1 || bus.dup_err !== 1'b0) begin errors++; $display("FAIL dup_first: got we=%b err=%b expected 1 0", bus.mem_we, bus.dup_err); end
    drive(3'd3, 32'h2222_2222);
`ifdef WR_DUP_CHECK_EN
    checks++; if (bus.mem_we !== 1'b0 || bus.dup_err !== 1'b1) begin errors++; $display("FAIL dup_second: got we=%b err=%b expected 0 1", bus.mem_we, bus.dup_err); end
`else
    checks++; if (bus.mem_we !== 1'b1 || bus.dup_err !== 1'b0 || bus.mem_wdata !== 32'h2222_2222) begin errors++; $display("FAIL dup_second: got we=%b err=%b data=%h expected 1 0 22222222", bus.mem_we, bus.dup_err, bus.mem_wdata); end
`endif
    for (int i = 0; i < 6; i++) begin
      drive(dtags[i], 32'h3000_0000 + i);
      checks++; if (bus.mem0_lock !== 1'b0 || bus.dup_err !== 1'b0 || bus.mem_we !== 1'b1) begin errors++; $display("FAIL dup_partial[%0d]: got lock0=%b err=%b we=%b expected 0 0 1", i, bus.mem0_lock, bus.dup_err, bus.mem_we); end
    end
    drive(3'd7, 32'h3000_0007);
    checks++; if (bus.mem0_lock !== 1'b1) begin errors++; $display("FAIL dup_lock: got %b expected 1", bus.mem0_lock); end
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 4; i++) begin
      drive(3'(i), 32'h4000_0000 + i);
      checks++; if (bus.mem_sel !== 1'b1) begin errors++; $display("FAIL rstmid_sel1[%0d]: got %b expected 1", i, bus.mem_sel); end
    end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (bus.mem0_lock !== 1'b0 || bus.mem1_lock !== 1'b0 || bus.mem_we !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_clear: got lock0=%b lock1=%b we=%b ready=%b expected 0 0 0 1", bus.mem0_lock, bus.mem1_lock, bus.mem_we, bus.in_ready); end
    for (int i = 0; i < 8; i++) begin
      drive(tags0[i], 32'h5000_0000 + i);
      checks++; if (bus.mem_sel !== 1'b0 || bus.mem0_lock !== (i == 7)) begin errors++; $display("FAIL rstmid_refill[%0d]: got sel=%b lock0=%b expected 0 %b", i, bus.mem_sel, bus.mem0_lock, i == 7); end
    end
  endtask

  task automatic test_spurious();
    for (int i = 0; i < 3; i++) drive(3'(i), 32'h6000_0000 + i);
    bus.mem1_free = 1'b1;
    tick();
    bus.mem1_free = 1'b0;
    checks++; if (bus.mem0_lock !== 1'b1 || bus.mem1_lock !== 1'b0 || bus.in_ready !== 1'b1 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL spur_free: got lock0=%b lock1=%b ready=%b we=%b expected 1 0 1 0", bus.mem0_lock, bus.mem1_lock, bus.in_ready, bus.mem_we); end
    for (int i = 3; i < 8; i++) begin
      drive(3'(i), 32'h6000_0000 + i);
      checks++; if (bus.mem_sel !== 1'b1 || bus.mem1_lock !== (i == 7)) begin errors++; $display("FAIL spur_fill[%0d]: got sel=%b lock1=%b expected 1 %b", i, bus.mem_sel, bus.mem1_lock, i == 7); end
    end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL spur_wait: got ready=%b expected 0", bus.in_ready); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_wait();
    test_overlap();
    test_dup();
    test_rst_mid();
    test_spurious();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
